// File: rtl/pio_fb_write_bridge_pkg.sv
// Shared definitions for the PIO framebuffer write bridge: command modes,
// PIO flag bit positions, FSM state type and the broadcast channel index.
package pio_fb_pkg;

  // Command modes carried in pio_out_flags[2:1]
  localparam logic [1:0] MODE_SINGLE  = 2'b00;
  localparam logic [1:0] MODE_AUTOINC = 2'b01;
  localparam logic [1:0] MODE_FILL    = 2'b10;
  localparam logic [1:0] MODE_PTRLD   = 2'b11;

  // pio_out_flags fields (CPU -> bridge)
  localparam int REQ_BIT  = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int CH_LSB   = 4;
  localparam int CH_MSB   = 7;

  // pio_in_flags fields (bridge -> CPU)
  localparam int ACK_BIT  = 0;
  localparam int BUSY_BIT = 1;
  localparam int ERR_BIT  = 2;

  // Channel index that addresses every panel when broadcast is built in
  localparam logic [3:0] BCAST_CH = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_ACK   = 2'd3
  } pio_fb_state_e;

endpackage

// File: rtl/pio_fb_write_bridge_if.sv
// Bus bundle between the CPU PIO exports / framebuffer ports and the bridge.
//
// Handshakes:
//   CPU side is a toggle req/ack pair. The CPU sets up pio_addr, pio_data and
//   the mode/channel fields, then flips pio_out_flags[0]. The bridge flips
//   pio_in_flags[0] once the command has finished; busy is high from command
//   detection until the bridge is back in IDLE. One command may be in flight.
//   Framebuffer side is valid/ready style: fb_we != 0 is "valid", !fb_wait is
//   "ready". A write transfers on a clock edge where both hold; while fb_wait
//   is high, fb_we/fb_addr/fb_data are held unchanged.
interface pio_fb_write_bridge_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24,
  parameter int NUM_CH = 1
);
  logic [ADDR_W-1:0] pio_addr;
  logic [DATA_W-1:0] pio_data;
  logic [7:0]        pio_out_flags;
  logic [7:0]        pio_in_flags;
  logic [NUM_CH-1:0] fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [DATA_W-1:0] fb_data;
  logic              fb_wait;

  // Bridge side
  modport slave (
    input  pio_addr, pio_data, pio_out_flags, fb_wait,
    output pio_in_flags, fb_we, fb_addr, fb_data
  );

  // CPU / framebuffer environment side
  modport master (
    output pio_addr, pio_data, pio_out_flags, fb_wait,
    input  pio_in_flags, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/pio_fb_write_bridge_chsel.sv
// Channel index to one-hot write-enable mask, flagging out-of-range indices.
// Optional macro PIO_FB_BROADCAST_EN: index 4'hF enables every channel.
module pio_fb_chsel
  import pio_fb_pkg::*;
#(
  parameter int NUM_CH = 1
) (
  input  logic [3:0]        ch,
  output logic [NUM_CH-1:0] mask,
  output logic              ch_err
);

  // Decode the channel; an out-of-range index yields an empty mask
  always_comb begin
    mask   = '0;
    ch_err = (32'(ch) >= 32'(NUM_CH));
    for (int i = 0; i < NUM_CH; i++) begin
      mask[i] = (32'(ch) == 32'(i));
    end
`ifdef PIO_FB_BROADCAST_EN
    if (ch == BCAST_CH) begin
      mask   = '1;
      ch_err = 1'b0;
    end
`else
    // Without broadcast the all-ones index is just another bad channel
    if (ch == BCAST_CH) begin
      mask   = '0;
      ch_err = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/pio_fb_write_bridge.sv
// CPU PIO to framebuffer write bridge: toggle req/ack command interface,
// per-panel channel select, auto-increment pointer, hardware fill and
// fb_wait backpressure. Optional macro: PIO_FB_BROADCAST_EN.
module pio_fb_write_bridge
  import pio_fb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24,
  parameter int NUM_CH = 1,
  parameter int DEPTH  = 4096
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset,
  pio_fb_write_bridge_if.slave bus,
  output pio_fb_state_e        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Registered CPU inputs
  logic              req_reg;
  logic [1:0]        mode_reg;
  logic [3:0]        ch_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;

  // Command capture
  logic              armed, req_last, cmd_pend;
  logic [1:0]        cmd_mode;
  logic [3:0]        cmd_ch;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  // Execution state
  pio_fb_state_e     state, state_nxt;
  logic [ADDR_W-1:0] ptr, fill_addr;
  logic              ack_q, err_q;
  logic [NUM_CH-1:0] ch_mask;
  logic              ch_err;
  logic              detect, dispatch, addr_oob, cmd_bad, enter_ack, wr_done, fill_step;
  logic              unused_rsvd;

  // Reserved flag bit is intentionally ignored
  assign unused_rsvd = bus.pio_out_flags[3];

  pio_fb_chsel #(.NUM_CH(NUM_CH)) u_chsel (
    .ch     (cmd_ch),
    .mask   (ch_mask),
    .ch_err (ch_err)
  );

  // A new toggle is only taken in IDLE, so a toggle arriving while busy waits
  assign detect    = armed && (state == ST_IDLE) && !cmd_pend && (req_reg != req_last);
  assign dispatch  = (state == ST_IDLE) && cmd_pend;
  assign addr_oob  = (32'(cmd_addr) >= 32'(DEPTH));
  assign cmd_bad   = ch_err || (addr_oob && ((cmd_mode == MODE_SINGLE) || (cmd_mode == MODE_FILL)));
  assign enter_ack = (state_nxt == ST_ACK) && (state != ST_ACK);
  assign wr_done   = (state == ST_WRITE) && !bus.fb_wait;
  assign fill_step = (state == ST_FILL) && !bus.fb_wait;
  assign dbg_state = state;

  // Register CPU inputs and capture a command on a req toggle
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      req_reg  <= 1'b0;
      mode_reg <= '0;
      ch_reg   <= '0;
      addr_reg <= '0;
      data_reg <= '0;
      armed    <= 1'b0;
      req_last <= 1'b0;
      cmd_pend <= 1'b0;
      cmd_mode <= '0;
      cmd_ch   <= '0;
      cmd_addr <= '0;
      cmd_data <= '0;
    end else begin
      req_reg  <= bus.pio_out_flags[REQ_BIT];
      mode_reg <= bus.pio_out_flags[MODE_MSB:MODE_LSB];
      ch_reg   <= bus.pio_out_flags[CH_MSB:CH_LSB];
      addr_reg <= bus.pio_addr;
      data_reg <= bus.pio_data;
      if (!armed) begin
        // Adopt whatever req level survived reset so it is not seen as a toggle
        armed    <= 1'b1;
        req_last <= bus.pio_out_flags[REQ_BIT];
      end else if (detect) begin
        req_last <= req_reg;
        cmd_pend <= 1'b1;
        cmd_mode <= mode_reg;
        cmd_ch   <= ch_reg;
        cmd_addr <= addr_reg;
        cmd_data <= data_reg;
      end
      if (dispatch) begin
        cmd_pend <= 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Next-state: dispatch a pending command, finish writes/fill, then ack
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_pend) begin
          if ((cmd_mode == MODE_PTRLD) || cmd_bad) state_nxt = ST_ACK;
          else if (cmd_mode == MODE_FILL)          state_nxt = ST_FILL;
          else                                     state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: if (!bus.fb_wait) state_nxt = ST_ACK;
      ST_FILL:  if (!bus.fb_wait && (fill_addr == LAST_ADDR)) state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Pointer, fill address, ack toggle and sticky error
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      ptr       <= '0;
      fill_addr <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (dispatch) begin
        fill_addr <= cmd_addr;
        if (cmd_mode == MODE_PTRLD) begin
          ptr   <= cmd_addr;
          err_q <= 1'b0;
        end else if (cmd_bad) begin
          err_q <= 1'b1;
        end
      end
      if (wr_done && (cmd_mode == MODE_AUTOINC)) begin
        ptr <= (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
      end
      if (fill_step && (fill_addr != LAST_ADDR)) begin
        fill_addr <= fill_addr + 1'b1;
      end
      if (enter_ack) begin
        ack_q <= ~ack_q;
      end
    end
  end

  // Outputs: write strobes only in WRITE/FILL, status flags from registers
  always_comb begin
    bus.fb_we   = '0;
    bus.fb_addr = cmd_addr;
    bus.fb_data = cmd_data;
    if (state == ST_WRITE) begin
      bus.fb_we = ch_mask;
      if (cmd_mode == MODE_AUTOINC) bus.fb_addr = ptr;
    end else if (state == ST_FILL) begin
      bus.fb_we   = ch_mask;
      bus.fb_addr = fill_addr;
    end
    bus.pio_in_flags           = '0;
    bus.pio_in_flags[ACK_BIT]  = ack_q;
    bus.pio_in_flags[BUSY_BIT] = cmd_pend || (state != ST_IDLE);
    bus.pio_in_flags[ERR_BIT]  = err_q;
  end

endmodule

// File: tb/tb_pio_fb_write_bridge.sv
// Bench for pio_fb_write_bridge (NUM_CH=2, DEPTH=4096). A command-level model
// predicts the framebuffer writes, ack parity, pointer and error flag.
module tb_pio_fb_write_bridge;
  import pio_fb_pkg::*;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 24;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4096;
  localparam int EW     = NUM_CH + ADDR_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pio_fb_write_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();
  pio_fb_state_e dbg_state;

  pio_fb_write_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0]     exp_q[$];
  logic [ADDR_W-1:0] wr_log[$];
  logic [NUM_CH-1:0] we_log[$];
  logic              req_state;
  logic              ack_m;
  logic              err_m;
  int                ptr_m;
  logic              wait_mode;
  int                ack_edges = 0;
  logic              prev_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic m_bad(input logic [3:0] ch);
`ifdef PIO_FB_BROADCAST_EN
    if (ch == 4'hF) return 1'b0;
`endif
    return int'(ch) >= NUM_CH;
  endfunction

  function automatic logic [NUM_CH-1:0] m_mask(input logic [3:0] ch);
`ifdef PIO_FB_BROADCAST_EN
    if (ch == 4'hF) return '1;
`endif
    return NUM_CH'(1) << ch;
  endfunction

  task automatic model_cmd(input logic [1:0] mode, input logic [3:0] ch,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    case (mode)
      MODE_PTRLD: begin
        ptr_m = int'(addr);
        err_m = 1'b0;
      end
      MODE_SINGLE: begin
        if (m_bad(ch) || int'(addr) >= DEPTH) err_m = 1'b1;
        else exp_q.push_back({m_mask(ch), addr, data});
      end
      MODE_AUTOINC: begin
        if (m_bad(ch)) err_m = 1'b1;
        else begin
          exp_q.push_back({m_mask(ch), ADDR_W'(ptr_m), data});
          ptr_m = (ptr_m + 1) % DEPTH;
        end
      end
      default: begin
        if (m_bad(ch) || int'(addr) >= DEPTH) err_m = 1'b1;
        else for (int a = int'(addr); a < DEPTH; a++) exp_q.push_back({m_mask(ch), ADDR_W'(a), data});
      end
    endcase
    ack_m = ~ack_m;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic [1:0] mode, input logic [3:0] ch,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    req_state         = ~req_state;
    bus.pio_addr      = addr;
    bus.pio_data      = data;
    bus.pio_out_flags = {ch, 1'b0, mode, req_state};
    model_cmd(mode, ch, addr, data);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(bus.pio_in_flags[ACK_BIT] === ack_m && bus.pio_in_flags[BUSY_BIT] === 1'b0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ack"}, 64'(bus.pio_in_flags[ACK_BIT]), 64'(ack_m));
    chk({name, "_busy"}, 64'(bus.pio_in_flags[BUSY_BIT]), 64'd0);
    chk({name, "_err"}, 64'(bus.pio_in_flags[ERR_BIT]), 64'(err_m));
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic send_cmd(input string name, input logic [1:0] mode, input logic [3:0] ch,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(posedge clk);
    #1;
    drive_cmd(mode, ch, addr, data);
    wait_done(name);
  endtask

  // fb_wait: held low, or toggled every cycle when wait_mode is set
  always @(posedge clk) begin
    #1;
    bus.fb_wait = wait_mode ? ~bus.fb_wait : 1'b0;
  end

  // ---------------- compare process ----------------
  logic              prev_stall = 1'b0;
  logic [NUM_CH-1:0] prev_we;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;
  logic [NUM_CH-1:0] e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;

  // Every accepted write must match the next model write; stalled writes hold
  always @(negedge clk) begin
    if (bus.pio_in_flags[ACK_BIT] !== prev_ack) ack_edges++;
    prev_ack = bus.pio_in_flags[ACK_BIT];
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_we", 64'(bus.fb_we), 64'(prev_we));
        chk("hold_addr", 64'(bus.fb_addr), 64'(prev_addr));
        chk("hold_data", 64'(bus.fb_data), 64'(prev_data));
      end
      if (bus.fb_we != '0) begin
        if (!bus.fb_wait) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 64'(bus.fb_we), 64'd0);
          end else begin
            {e_we, e_addr, e_data} = exp_q.pop_front();
            chk("wr_we", 64'(bus.fb_we), 64'(e_we));
            chk("wr_addr", 64'(bus.fb_addr), 64'(e_addr));
            chk("wr_data", 64'(bus.fb_data), 64'(e_data));
            wr_log.push_back(bus.fb_addr);
            we_log.push_back(bus.fb_we);
          end
        end
        prev_stall = bus.fb_wait;
        prev_we    = bus.fb_we;
        prev_addr  = bus.fb_addr;
        prev_data  = bus.fb_data;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Hard stop if the run wedges
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  int edges0;

  initial begin
    rst               = 1'b1;
    wait_mode         = 1'b0;
    req_state         = 1'b1;
    ack_m             = 1'b0;
    err_m             = 1'b0;
    ptr_m             = 0;
    bus.pio_addr      = '0;
    bus.pio_data      = '0;
    bus.pio_out_flags = 8'h01;   // stale req level held through reset

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fb_we", 64'(bus.fb_we), 64'd0);
    chk("rst_fb_addr", 64'(bus.fb_addr), 64'd0);
    chk("rst_fb_data", 64'(bus.fb_data), 64'd0);
    chk("rst_in_flags", 64'(bus.pio_in_flags), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // Release with req=1: no command may result
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("stale_in_flags", 64'(bus.pio_in_flags), 64'd0);
    chk("stale_state", 64'(dbg_state), 64'(ST_IDLE));

    // Single write with exact latency
    wr_log.delete();
    @(posedge clk);
    #1 drive_cmd(MODE_SINGLE, 4'd0, 12'h010, 24'hFF0000);
    @(negedge clk);
    @(negedge clk);                       // toggle now registered
    chk("lat_n_we", 64'(bus.fb_we), 64'd0);
    @(negedge clk);                       // detection edge passed
    chk("lat_n1_we", 64'(bus.fb_we), 64'd0);
    chk("lat_n1_busy", 64'(bus.pio_in_flags[BUSY_BIT]), 64'd1);
    @(negedge clk);
    chk("lat_n2_we", 64'(bus.fb_we), 64'b01);
    chk("lat_n2_addr", 64'(bus.fb_addr), 64'h010);
    chk("lat_n2_data", 64'(bus.fb_data), 64'hFF0000);
    chk("lat_n2_ack", 64'(bus.pio_in_flags[ACK_BIT]), 64'd0);
    @(negedge clk);
    chk("lat_n3_ack", 64'(bus.pio_in_flags[ACK_BIT]), 64'd1);
    chk("lat_n3_we", 64'(bus.fb_we), 64'd0);
    wait_done("single");
    chk("single_count", 64'(wr_log.size()), 64'd1);

    // Pointer load then auto-increment across the wrap
    wr_log.delete();
    edges0 = ack_edges;
    send_cmd("ptrld_ffe", MODE_PTRLD, 4'd0, 12'hFFE, 24'h000000);
    send_cmd("auto0", MODE_AUTOINC, 4'd0, 12'h000, 24'h112233);
    send_cmd("auto1", MODE_AUTOINC, 4'd0, 12'h000, 24'h445566);
    send_cmd("auto2", MODE_AUTOINC, 4'd1, 12'h000, 24'h778899);
    chk("auto_count", 64'(wr_log.size()), 64'd3);
    if (wr_log.size() == 3) begin
      chk("auto_addr0", 64'(wr_log[0]), 64'hFFE);
      chk("auto_addr1", 64'(wr_log[1]), 64'hFFF);
      chk("auto_addr2", 64'(wr_log[2]), 64'h000);
    end
    chk("auto_ack_edges", 64'(ack_edges - edges0), 64'd4);

    // Fill to the top of the channel-1 buffer with fb_wait toggling
    wr_log.delete();
    we_log.delete();
    edges0    = ack_edges;
    wait_mode = 1'b1;
    send_cmd("fill", MODE_FILL, 4'd1, 12'hFF0, 24'hA5A5A5);
    wait_mode = 1'b0;
    chk("fill_count", 64'(wr_log.size()), 64'd16);
    if (wr_log.size() == 16) begin
      chk("fill_first", 64'(wr_log[0]), 64'hFF0);
      chk("fill_last", 64'(wr_log[15]), 64'hFFF);
      chk("fill_we", 64'(we_log[15]), 64'b10);
    end
    chk("fill_ack_edges", 64'(ack_edges - edges0), 64'd1);

    // Errors: bad channel, sticky across a good write, cleared by pointer load
    wr_log.delete();
    send_cmd("bad_ch3", MODE_SINGLE, 4'd3, 12'h020, 24'h123456);
    chk("bad_ch3_err_lit", 64'(bus.pio_in_flags[ERR_BIT]), 64'd1);
    send_cmd("good_sticky", MODE_SINGLE, 4'd1, 12'h123, 24'h00ABCD);
    send_cmd("ptrld_clr", MODE_PTRLD, 4'd0, 12'h000, 24'h000000);
    chk("clr_err_lit", 64'(bus.pio_in_flags[ERR_BIT]), 64'd0);
    send_cmd("ch_f", MODE_SINGLE, 4'hF, 12'h040, 24'h0000FF);
`ifdef PIO_FB_BROADCAST_EN
    chk("bcast_we", 64'(we_log.size() > 0 ? we_log[we_log.size()-1] : '0), 64'b11);
`else
    chk("ch_f_err_lit", 64'(bus.pio_in_flags[ERR_BIT]), 64'd1);
`endif
    send_cmd("bad_fill", MODE_FILL, 4'd2, 12'hFFC, 24'h010203);
    send_cmd("ptrld_clr2", MODE_PTRLD, 4'd0, 12'h000, 24'h000000);

    // Reset in the middle of a fill
    @(posedge clk);
    #1 drive_cmd(MODE_FILL, 4'd1, 12'hF00, 24'h0F0F0F);
    for (int n = 0; n < 20 && bus.fb_we == '0; n++) @(negedge clk);
    chk("midfill_active", 64'(bus.fb_we), 64'b10);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midfill_we", 64'(bus.fb_we), 64'd0);
    chk("midfill_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("midfill_flags", 64'(bus.pio_in_flags), 64'd0);
    exp_q.delete();
    ack_m = 1'b0;
    err_m = 1'b0;
    ptr_m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_flags", 64'(bus.pio_in_flags), 64'd0);
    chk("post_rst_we", 64'(bus.fb_we), 64'd0);

    // Normal operation resumes after reset
    send_cmd("post_rst_auto", MODE_AUTOINC, 4'd1, 12'h777, 24'h55AA55);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
